leaf_stream_packetizer: RTL and testbench
=========================================

// Module: leaf_stream_packetizer
// PURPOSE
//  Transmit stage between a leaf's user kernel output stream and the BFT network.
//  - Accepts 32-bit words on a vld/ack handshake and buffers them in a small FIFO.
//  - Wraps each word into a 49-bit BFT packet: {valid, dst_leaf, dst_port, addr, payload}.
//  - Obeys receiver free-space credits and replays the last packet when the network asserts resend.
// PARAMETERS
//  PAYLOAD_BITS   32  user word width
//  NUM_LEAF_BITS  5   destination leaf field width
//  NUM_PORT_BITS  4   destination port field width
//  NUM_ADDR_BITS  7   sequence/address field width; also sets receiver buffer size 2**NUM_ADDR_BITS
//  PACKET_BITS    49  must equal 1+NUM_LEAF_BITS+NUM_PORT_BITS+NUM_ADDR_BITS+PAYLOAD_BITS
//  FIFO_DEPTH     4   input buffer entries (power of 2)
//  CREDIT_INIT    64  credits after reset (matches receiver FREESPACE_UPDATE_SIZE)
// PORTS
//  clk                      in  1            single clock
//  reset                    in  1            asynchronous, active-high
//  dst_leaf                 in  NUM_LEAF_BITS  static destination leaf
//  dst_port                 in  NUM_PORT_BITS  static destination port
//  din_leaf_user2interface  in  PAYLOAD_BITS   user word
//  vld_user2interface       in  1            user word valid
//  ack_interface2user       out 1            word accepted this cycle when vld&ack
//  credit_vld               in  1            one-cycle credit return pulse
//  credit_amt               in  NUM_ADDR_BITS+1  credits returned with credit_vld
//  resend                   in  1            network rejected last packet; re-emit it
//  dout_leaf_interface2bft  out PACKET_BITS  registered packet to BFT; bit MSB = valid
//  credit_count             out NUM_ADDR_BITS+1  current credits (status)
// BEHAVIOUR
//  Packet layout (MSB..LSB):
//    [48] valid, [47:43] leaf, [42:39] port, [38:32] addr, [31:0] payload
//  Reset values:
//    dout = 0; credit_count = CREDIT_INIT; addr counter = 0; FIFO empty; ack = 1 once reset deasserts
//  Input side:
//    ack_interface2user = !fifo_full (combinational); push on vld&ack
//  Per cycle, after the clock edge, in strict priority:
//    1. resend=1 -> dout holds its value (even if 0); no pop; addr and credits unchanged
//    2. else if fifo nonempty and credit_count>0 -> pop and emit
//       dout = {1, dst_leaf, dst_port, addr, word}; addr++ (wraps 127->0); credit_count--
//    3. else -> dout = 0 (valid low, no packet)
//  Latency: a word pushed at edge t appears on dout at edge t+1 at the earliest (FIFO fall-through registered once)
//  Credits:
//    - credit_vld adds credit_amt; saturates at 2**NUM_ADDR_BITS
//    - simultaneous emit and credit_vld: net = credits + amt - 1
//  FIFO boundaries:
//    - simultaneous push and pop when full: allowed only if pop occurs; ack stays !full (no bypass)
//    - push when empty with credit available: word is emitted next edge
//  Resend at cycle 0 after reset or on an idle cycle is harmless (holds 0)
//  FSM state (2-bit):
//    EMIT  (last cycle sent a packet)
//    IDLE  (fifo empty)
//    STALL (fifo nonempty, credit_count==0)
//    HOLD  (resend)
//  Transitions follow the priority above. State is diagnostic only; all outputs derive from the datapath rules.
//  Reset mid-operation: FIFO contents discarded; outputs return to reset values asynchronously.
// STRUCTURE
//  - Package leaf_pkt_pkg: field offsets/widths (VALID_BIT, LEAF_LSB, PORT_LSB, ADDR_LSB), the state enum, packet assembly function.
//  - Sub-module leaf_sync_fifo (WIDTH, DEPTH; push/pop/full/empty, async reset), instantiated once.
//  - Remaining logic (credit counter, addr counter, output register, FSM) lives in this module.
// TESTING
//  - Reset: assert reset mid-stream -> dout=0, credit_count=64, ack=1 after release, next packet addr=0.
//  - Single word: dst_leaf=3, dst_port=1, word 32'hDEADBEEF -> next edge dout=49'h1_1880_DEAD_BEEF, credit_count=63.
//  - Resend: emit a packet, then resend=1 for 2 cycles -> dout repeats the same packet 2 more cycles; next emit carries addr=1.
//  - Credit stall: CREDIT_INIT=2, push 3 words -> 2 packets then dout=0 (STALL); credit_vld with amt=1 -> third packet; credit_count=0.
//  - FIFO full: credits 0, push 4 words -> ack=0 on the 5th; one credit returned -> one pop, ack=1 next cycle.
//  - Wrap/saturate: send 130 packets with credits replenished -> addr sequence 0..127,0,1; credit_vld amt=128 at 127 credits -> count=128.

Source files
------------

// File: rtl/leaf_pkt_pkg.sv
// Shared definitions for the leaf stream packetizer.
// Provides the BFT packet field widths and offsets, the diagnostic FSM state
// encoding and the function that assembles a packet from its fields.
// Packet layout (MSB..LSB): valid | dst_leaf | dst_port | addr | payload
package leaf_pkt_pkg;

  localparam int PKT_PAYLOAD_BITS  = 32;
  localparam int PKT_LEAF_BITS     = 5;
  localparam int PKT_PORT_BITS     = 4;
  localparam int PKT_ADDR_BITS     = 7;
  localparam int PKT_BITS          = 1 + PKT_LEAF_BITS + PKT_PORT_BITS + PKT_ADDR_BITS + PKT_PAYLOAD_BITS;

  localparam int ADDR_LSB  = PKT_PAYLOAD_BITS;          // 32
  localparam int PORT_LSB  = ADDR_LSB + PKT_ADDR_BITS;  // 39
  localparam int LEAF_LSB  = PORT_LSB + PKT_PORT_BITS;  // 43
  localparam int VALID_BIT = LEAF_LSB + PKT_LEAF_BITS;  // 48

  // Diagnostic state encoding; outputs never depend on it.
  typedef logic [1:0] state_t;
  localparam state_t ST_EMIT  = 2'd0;  // last cycle sent a packet
  localparam state_t ST_IDLE  = 2'd1;  // fifo empty
  localparam state_t ST_STALL = 2'd2;  // fifo holds data but no credit
  localparam state_t ST_HOLD  = 2'd3;  // network requested a resend

  // Assemble a valid packet from its fields.
  function automatic logic [PKT_BITS-1:0] build_packet(
    input logic [PKT_LEAF_BITS-1:0]    leaf,
    input logic [PKT_PORT_BITS-1:0]    port,
    input logic [PKT_ADDR_BITS-1:0]    addr,
    input logic [PKT_PAYLOAD_BITS-1:0] payload
  );
    logic [PKT_BITS-1:0] pkt;
    pkt                              = {PKT_BITS{1'b0}};
    pkt[VALID_BIT]                   = 1'b1;
    pkt[VALID_BIT-1:LEAF_LSB]        = leaf;
    pkt[LEAF_LSB-1:PORT_LSB]         = port;
    pkt[PORT_LSB-1:ADDR_LSB]         = addr;
    pkt[ADDR_LSB-1:0]                = payload;
    return pkt;
  endfunction

endpackage

// File: rtl/leaf_sync_fifo.sv
// Small synchronous FIFO used as the packetizer input buffer.
// The head entry is presented combinationally on rdata (fall-through read),
// so a consumer can register it on the same edge that pops it.
// Ports:
//   clk, reset     clock and asynchronous active-high reset (empties the FIFO)
//   push, wdata    write request and data; ignored when full
//   pop            read request; ignored when empty
//   rdata          head entry (valid while !empty)
//   full, empty    occupancy status
module leaf_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_q == (AW+1)'(DEPTH));
  assign empty     = (count_q == {(AW+1){1'b0}});
  assign do_push_s = push & ~full;
  assign do_pop_s  = pop & ~empty;
  assign rdata     = mem_q[rptr_q];

  // Next-state for pointers and occupancy; pointers wrap naturally (DEPTH is a power of 2).
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push_s) begin
      wptr_d = wptr_q + AW'(1);
    end else begin
      wptr_d = wptr_q;
    end
    if (do_pop_s) begin
      rptr_d = rptr_q + AW'(1);
    end else begin
      rptr_d = rptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q  <= {AW{1'b0}};
      rptr_q  <= {AW{1'b0}};
      count_q <= {(AW+1){1'b0}};
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/leaf_stream_packetizer.sv
// Transmit stage between a leaf's user output stream and the BFT network.
// Buffers user words, wraps each one into a BFT packet, spends one receiver
// credit per packet and re-presents the last packet while resend is high.
// Ports:
//   clk, reset                 clock and asynchronous active-high reset
//   dst_leaf, dst_port         static destination fields
//   din_leaf_user2interface    user word; accepted when vld & ack
//   vld_user2interface         user word valid
//   ack_interface2user         !fifo_full (combinational)
//   credit_vld, credit_amt     credit return pulse and amount
//   resend                     hold the current output packet
//   dout_leaf_interface2bft    registered packet, MSB is valid
//   credit_count               current credit balance
module leaf_stream_packetizer
  import leaf_pkt_pkg::*;
#(
  parameter int PAYLOAD_BITS  = PKT_PAYLOAD_BITS,
  parameter int NUM_LEAF_BITS = PKT_LEAF_BITS,
  parameter int NUM_PORT_BITS = PKT_PORT_BITS,
  parameter int NUM_ADDR_BITS = PKT_ADDR_BITS,
  parameter int PACKET_BITS   = PKT_BITS,
  parameter int FIFO_DEPTH    = 4,
  parameter int CREDIT_INIT   = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_LEAF_BITS-1:0] dst_leaf,
  input  logic [NUM_PORT_BITS-1:0] dst_port,
  input  logic [PAYLOAD_BITS-1:0]  din_leaf_user2interface,
  input  logic                     vld_user2interface,
  output logic                     ack_interface2user,
  input  logic                     credit_vld,
  input  logic [NUM_ADDR_BITS:0]   credit_amt,
  input  logic                     resend,
  output logic [PACKET_BITS-1:0]   dout_leaf_interface2bft,
  output logic [NUM_ADDR_BITS:0]   credit_count
);

  localparam int CW = NUM_ADDR_BITS + 1;
  // One extra bit so credits + returned amount cannot overflow before saturation.
  localparam logic [CW:0] CREDIT_MAX = (CW+1)'(2**NUM_ADDR_BITS);

  logic [PAYLOAD_BITS-1:0]  fifo_rdata_s;
  logic                     fifo_full_s;
  logic                     fifo_empty_s;
  logic                     fifo_push_s;
  logic                     emit_s;
  logic [CW:0]              credit_sum_s;
  state_t                   prio_state_s;

  logic [PACKET_BITS-1:0]   dout_q, dout_d;
  logic [NUM_ADDR_BITS-1:0] addr_q, addr_d;
  logic [CW-1:0]            credit_q, credit_d;
  state_t                   state_q, state_d;

  assign ack_interface2user      = ~fifo_full_s;
  assign fifo_push_s             = vld_user2interface & ~fifo_full_s;
  // Resend wins over everything; otherwise emit needs data and a credit.
  assign emit_s                  = ~resend & ~fifo_empty_s & (credit_q != {CW{1'b0}});
  assign dout_leaf_interface2bft = dout_q;
  assign credit_count            = credit_q;

  leaf_sync_fifo #(
    .WIDTH (PAYLOAD_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push_s),
    .wdata (din_leaf_user2interface),
    .pop   (emit_s),
    .rdata (fifo_rdata_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // Output packet and sequence address.
  always_comb begin
    dout_d = dout_q;
    addr_d = addr_q;
    if (resend) begin
      dout_d = dout_q;
      addr_d = addr_q;
    end else if (emit_s) begin
      dout_d = build_packet(dst_leaf, dst_port, addr_q, fifo_rdata_s);
      addr_d = addr_q + NUM_ADDR_BITS'(1);
    end else begin
      dout_d = {PACKET_BITS{1'b0}};
      addr_d = addr_q;
    end
  end

  // Credit balance: spend one per emitted packet, add returns, clamp at buffer size.
  always_comb begin
    credit_sum_s = {1'b0, credit_q};
    if (emit_s) begin
      credit_sum_s = credit_sum_s - (CW+1)'(1);
    end else begin
      credit_sum_s = credit_sum_s;
    end
    if (credit_vld) begin
      credit_sum_s = credit_sum_s + {1'b0, credit_amt};
    end else begin
      credit_sum_s = credit_sum_s;
    end
    if (credit_sum_s > CREDIT_MAX) begin
      credit_d = CREDIT_MAX[CW-1:0];
    end else begin
      credit_d = credit_sum_s[CW-1:0];
    end
  end

  // Diagnostic state: every state follows the same datapath priority.
  always_comb begin
    if (resend) begin
      prio_state_s = ST_HOLD;
    end else if (emit_s) begin
      prio_state_s = ST_EMIT;
    end else if (fifo_empty_s) begin
      prio_state_s = ST_IDLE;
    end else begin
      prio_state_s = ST_STALL;
    end
    case (state_q)
      ST_EMIT:  state_d = prio_state_s;
      ST_IDLE:  state_d = prio_state_s;
      ST_STALL: state_d = prio_state_s;
      ST_HOLD:  state_d = prio_state_s;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath, credit and state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout_q   <= {PACKET_BITS{1'b0}};
      addr_q   <= {NUM_ADDR_BITS{1'b0}};
      credit_q <= CW'(CREDIT_INIT);
      state_q  <= ST_IDLE;
    end else begin
      dout_q   <= dout_d;
      addr_q   <= addr_d;
      credit_q <= credit_d;
      state_q  <= state_d;
    end
  end

endmodule

// File: tb/tb_leaf_stream_packetizer.sv
module tb_leaf_stream_packetizer;

  logic        clk;
  logic        reset;
  logic [4:0]  dst_leaf;
  logic [3:0]  dst_port;
  logic [31:0] din;
  logic        vld;
  logic        ack;
  logic        credit_vld;
  logic [7:0]  credit_amt;
  logic        resend;
  logic [48:0] dout;
  logic [7:0]  credit_count;

  int checks;
  int errors;
  logic [48:0] exp_q[$];

  leaf_stream_packetizer dut (
    .clk                     (clk),
    .reset                   (reset),
    .dst_leaf                (dst_leaf),
    .dst_port                (dst_port),
    .din_leaf_user2interface (din),
    .vld_user2interface      (vld),
    .ack_interface2user      (ack),
    .credit_vld              (credit_vld),
    .credit_amt              (credit_amt),
    .resend                  (resend),
    .dout_leaf_interface2bft (dout),
    .credit_count            (credit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected packet for leaf 3, port 1.
  function automatic logic [48:0] pkt(input logic [6:0] a, input logic [31:0] w);
    return {1'b1, 5'd3, 4'd1, a, w};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every valid packet seen must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset && dout[48]) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pkt actual=%0h expected=none", dout);
      end else begin
        chk("pkt", {15'd0, dout}, {15'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; errors = 0;
    reset = 1'b1; dst_leaf = 5'd3; dst_port = 4'd1; din = 32'd0; vld = 1'b0;
    credit_vld = 1'b0; credit_amt = 8'd0; resend = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_dout", dout, 64'd0);
    chk("rst_credit", credit_count, 64'd64);
    chk("rst_ack", ack, 64'd1);

    // resend while idle holds zero
    resend = 1'b1; cyc(); resend = 1'b0;
    chk("idle_resend_dout", dout, 64'd0);
    chk("idle_resend_credit", credit_count, 64'd64);

    // single word
    exp_q.push_back(49'h1_1880_DEAD_BEEF);
    din = 32'hDEAD_BEEF; vld = 1'b1; cyc(); vld = 1'b0;
    chk("latency_dout", dout, 64'd0);
    cyc();
    chk("single_credit", credit_count, 64'd63);

    // resend: packet addr 1 repeats twice, word pushed during resend goes out after
    exp_q.push_back(pkt(7'd1, 32'h1234_5678));
    din = 32'h1234_5678; vld = 1'b1; cyc(); vld = 1'b0; cyc();
    exp_q.push_back(pkt(7'd1, 32'h1234_5678));
    exp_q.push_back(pkt(7'd1, 32'h1234_5678));
    resend = 1'b1; din = 32'hCAFE_F00D; vld = 1'b1; cyc(); vld = 1'b0; cyc();
    chk("resend_credit", credit_count, 64'd62);
    resend = 1'b0;
    exp_q.push_back(pkt(7'd2, 32'hCAFE_F00D));
    cyc();
    chk("after_resend_credit", credit_count, 64'd61);
    cyc();
    chk("after_resend_idle", dout, 64'd0);

    // stream 59 words to bring credits to 2
    for (int i = 0; i < 59; i++) begin
      exp_q.push_back(pkt(7'(3 + i), 32'h1000_0000 + i));
      din = 32'h1000_0000 + i; vld = 1'b1; cyc();
    end
    vld = 1'b0; cyc();
    chk("drain_credit", credit_count, 64'd2);

    // credit stall
    exp_q.push_back(pkt(7'd62, 32'hAAAA_0001));
    exp_q.push_back(pkt(7'd63, 32'hAAAA_0002));
    din = 32'hAAAA_0001; vld = 1'b1; cyc();
    din = 32'hAAAA_0002; cyc();
    din = 32'hAAAA_0003; cyc(); vld = 1'b0;
    cyc();
    chk("stall_dout", dout, 64'd0);
    chk("stall_credit", credit_count, 64'd0);
    credit_vld = 1'b1; credit_amt = 8'd1; cyc(); credit_vld = 1'b0;
    chk("stall_refill_dout", dout, 64'd0);
    chk("stall_refill_credit", credit_count, 64'd1);
    exp_q.push_back(pkt(7'd64, 32'hAAAA_0003));
    cyc();
    chk("stall_release_credit", credit_count, 64'd0);

    // fifo full with zero credits
    for (int i = 0; i < 4; i++) begin
      chk("fill_ack", ack, 64'd1);
      din = 32'hBB00_0000 + i; vld = 1'b1; cyc();
    end
    chk("full_ack", ack, 64'd0);
    din = 32'hBB00_0004; credit_vld = 1'b1; credit_amt = 8'd1; cyc(); credit_vld = 1'b0;
    chk("full_hold_ack", ack, 64'd0);
    chk("full_credit", credit_count, 64'd1);
    exp_q.push_back(pkt(7'd65, 32'hBB00_0000));
    cyc();
    chk("ack_after_pop", ack, 64'd1);
    chk("pop_credit", credit_count, 64'd0);
    cyc(); vld = 1'b0;
    chk("refull_ack", ack, 64'd0);

    // drain, including emit with simultaneous credit return
    credit_vld = 1'b1; credit_amt = 8'd4; cyc();
    chk("credit_add", credit_count, 64'd4);
    exp_q.push_back(pkt(7'd66, 32'hBB00_0001));
    exp_q.push_back(pkt(7'd67, 32'hBB00_0002));
    exp_q.push_back(pkt(7'd68, 32'hBB00_0003));
    exp_q.push_back(pkt(7'd69, 32'hBB00_0004));
    credit_amt = 8'd3; cyc(); credit_vld = 1'b0;
    chk("credit_net", credit_count, 64'd6);
    cyc(); cyc(); cyc();
    chk("drain2_credit", credit_count, 64'd3);
    cyc();
    chk("drain2_idle", dout, 64'd0);

    // saturation
    credit_vld = 1'b1; credit_amt = 8'd124; cyc();
    chk("credit_127", credit_count, 64'd127);
    credit_amt = 8'd128; cyc();
    chk("credit_sat", credit_count, 64'd128);
    cyc(); credit_vld = 1'b0;
    chk("credit_sat_again", credit_count, 64'd128);

    // reset mid-stream: third word still buffered is discarded
    exp_q.push_back(pkt(7'd70, 32'hCC00_0000));
    exp_q.push_back(pkt(7'd71, 32'hCC00_0001));
    din = 32'hCC00_0000; vld = 1'b1; cyc();
    din = 32'hCC00_0001; cyc();
    din = 32'hCC00_0002; cyc(); vld = 1'b0;
    #5;
    reset = 1'b1;
    #1;
    chk("async_rst_dout", dout, 64'd0);
    chk("async_rst_credit", credit_count, 64'd64);
    chk("async_rst_ack", ack, 64'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    cyc();
    chk("post_rst_dout", dout, 64'd0);
    resend = 1'b1; cyc(); resend = 1'b0;
    chk("post_rst_resend", dout, 64'd0);

    // 130 packets: addr runs 0..127,0,1
    for (int i = 0; i < 130; i++) begin
      exp_q.push_back(pkt(7'(i), 32'hA500_0000 + i));
      din = 32'hA500_0000 + i; vld = 1'b1; credit_vld = 1'b1; credit_amt = 8'd1; cyc();
    end
    vld = 1'b0; credit_vld = 1'b0; cyc();
    chk("wrap_credit", credit_count, 64'd64);
    cyc(); cyc();
    chk("wrap_idle", dout, 64'd0);
    chk("sb_drained", exp_q.size(), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
